// File: rtl/subleq_core_gen_if.sv
// subleq_core_gen_if: memory req/ack bus plus byte in/out streams of the SUBLEQ core
interface subleq_core_gen_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int IO_W   = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              in_valid;
  logic [IO_W-1:0]   in_data;
  logic              in_ready;
  logic              out_valid;
  logic [IO_W-1:0]   out_data;
  logic              out_ready;
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, in_ready, out_valid, out_data,
    input  mem_ack, mem_rdata, in_valid, in_data, out_ready
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, in_ready, out_valid, out_data,
    output mem_ack, mem_rdata, in_valid, in_data, out_ready
  );
endinterface

// File: rtl/subleq_core_gen.sv
// subleq_core_gen: parametrised SUBLEQ core with req/ack memory port, byte streams and halt
module subleq_core_gen #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter int              IO_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  subleq_core_gen_if.master  bus,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc
);
  typedef enum logic [3:0] {IDLE, FA, FB, FC, LA, LB, WB, UPD, IN, WI, OUT, HALT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, addr_t, pc1, pc2, pc3;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, da_q, da_d, db_q, db_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, r;
  logic [IO_W-1:0]   out_data_q, out_data_d;
  logic              req_q, req_d, we_q, we_d, in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d, halted_q, halted_d;
  logic              done, mem_st, taken;
  assign pc1    = pc_q + ADDR_W'(1);
  assign pc2    = pc_q + ADDR_W'(2);
  assign pc3    = pc_q + ADDR_W'(3);
  assign r      = db_q - da_q;
  assign taken  = r[DATA_W-1] | ~|r;
  assign done   = req_q & bus.mem_ack;
  assign mem_st = state_q inside {FA, FB, FC, LA, LB, WB, WI};
  assign addr_t = state_q == FA ? pc_q : state_q == FB ? pc1 : state_q == FC ? pc2 :
                  state_q == LA ? a_q[ADDR_W-1:0] : b_q[ADDR_W-1:0];
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign halted        = halted_q;
  assign pc            = pc_q;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    da_d        = da_q;
    db_d        = db_q;
    wdata_d     = wdata_q;
    out_data_d  = out_data_q;
    req_d       = req_q;
    we_d        = we_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
    // first cycle of a memory state issues the request, a later ack retires it
    if (mem_st && !req_q) begin
      req_d   = 1'b1;
      addr_d  = addr_t;
      we_d    = state_q inside {WB, WI};
      wdata_d = state_q == WB ? r : db_q;
    end
    if (done) req_d = 1'b0;
    case (state_q)
      IDLE: state_d = run ? FA : IDLE;
      FA: if (done) begin a_d = bus.mem_rdata; state_d = FB; end
      FB: if (done) begin b_d = bus.mem_rdata; state_d = FC; end
      FC: if (done) begin c_d = bus.mem_rdata; state_d = &a_q ? IN : LA; end
      LA: if (done) begin da_d = bus.mem_rdata; state_d = &b_q ? OUT : LB; end
      LB: if (done) begin db_d = bus.mem_rdata; state_d = WB; end
      WB: if (done) state_d = UPD;
      UPD: begin
        halted_d = taken & c_q[DATA_W-1];
        pc_d     = taken ? (c_q[DATA_W-1] ? pc_q : c_q[ADDR_W-1:0]) : pc3;
        state_d  = halted_d ? HALT : run ? FA : IDLE;
      end
      IN: begin
        in_ready_d = ~in_ready_q | ~bus.in_valid;
        if (in_ready_q && bus.in_valid) begin
          db_d    = DATA_W'(bus.in_data);
          state_d = WI;
        end
      end
      WI: if (done) begin pc_d = pc3; state_d = run ? FA : IDLE; end
      OUT: begin
        out_valid_d = ~out_valid_q | ~bus.out_ready;
        out_data_d  = out_valid_q ? out_data_q : da_q[IO_W-1:0];
        if (out_valid_q && bus.out_ready) begin
          pc_d    = pc3;
          state_d = run ? FA : IDLE;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      da_q        <= '0;
      db_q        <= '0;
      wdata_q     <= '0;
      out_data_q  <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      da_q        <= da_d;
      db_q        <= db_d;
      wdata_q     <= wdata_d;
      out_data_q  <= out_data_d;
      req_q       <= req_d;
      we_q        <= we_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end
endmodule

// File: tb/tb_subleq_core_gen.sv
// tb_subleq_core_gen: directed checks of the SUBLEQ core against hand-computed results
module tb_subleq_core_gen;
  logic clk = 1'b0;
  logic rst, run0, run1, halted0, halted1;
  logic [15:0] pc0, pc1;
  int tests = 0, fails = 0;
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];
  logic [15:0] snap [0:31];
  logic        ld_we = 1'b0, ld_sel = 1'b0, ld_clr = 1'b0;
  logic [15:0] ld_a = '0, ld_d = '0;
  int mode = 0, cnt0 = 0, lat0 = 0, req_n0 = 0, cyc = 0;
  logic [16:0] log0[$], log1[$];
  int ackc0[$];

  subleq_core_gen_if b0();
  subleq_core_gen_if b1();

  subleq_core_gen u0 (.clk(clk), .rst(rst), .run(run0), .bus(b0.master), .halted(halted0), .pc(pc0));
  subleq_core_gen #(.RESET_PC(16'hFFFE)) u1 (.clk(clk), .rst(rst), .run(run1), .bus(b1.master),
                                             .halted(halted1), .pc(pc1));

  always #5 clk = ~clk;

  // memory models: DUT0 with selectable ack latency, DUT1 zero latency
  assign b0.mem_ack   = b0.mem_req && cnt0 == lat0;
  assign b0.mem_rdata = mem0[b0.mem_addr];
  assign b1.mem_ack   = b1.mem_req;
  assign b1.mem_rdata = mem1[b1.mem_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld_we) begin
      if (ld_sel) mem1[ld_a] <= ld_d;
      else mem0[ld_a] <= ld_d;
    end
    if (ld_clr) for (int i = 0; i < 64; i++) mem0[i] <= '0;
    if (b0.mem_req) req_n0 <= req_n0 + 1;
    if (b0.mem_req && b0.mem_ack) begin
      if (b0.mem_we) mem0[b0.mem_addr] <= b0.mem_wdata;
      log0.push_back({b0.mem_we, b0.mem_addr});
      ackc0.push_back(cyc);
      cnt0 <= 0;
    end else if (b0.mem_req) cnt0 <= cnt0 + 1;
    else begin
      cnt0 <= 0;
      lat0 <= mode == 1 ? int'($urandom_range(7)) : mode == 2 ? 7 : 0;
    end
    if (b1.mem_req && b1.mem_ack) begin
      if (b1.mem_we) mem1[b1.mem_addr] <= b1.mem_wdata;
      log1.push_back({b1.mem_we, b1.mem_addr});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input logic sel, input logic [15:0] a, input logic [15:0] d);
    ld_we = 1'b1; ld_sel = sel; ld_a = a; ld_d = d;
    step(1);
    ld_we = 1'b0;
  endtask

  task automatic clr();
    ld_clr = 1'b1;
    step(1);
    ld_clr = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic pulse_run0();
    run0 = 1'b1;
    step(1);
    run0 = 1'b0;
  endtask

  task automatic load_t1();
    clr();
    poke(0, 0, 3); poke(0, 1, 4); poke(0, 2, 6); poke(0, 3, 7); poke(0, 4, 5);
  endtask

  initial begin
    int base, abase, n, w;
    logic [16:0] exp_log [6];
    rst = 1'b1; run0 = 1'b0; run1 = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    step(2);
    chk("rst_mem_req", b0.mem_req, 0);
    chk("rst_mem_we", b0.mem_we, 0);
    chk("rst_mem_addr", b0.mem_addr, 0);
    chk("rst_mem_wdata", b0.mem_wdata, 0);
    chk("rst_in_ready", b0.in_ready, 0);
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_out_data", b0.out_data, 0);
    chk("rst_halted", halted0, 0);
    chk("rst_pc", pc0, 0);
    chk("rst_pc_u1", pc1, 16'hFFFE);
    rst = 1'b0;

    // basic subleq: mem[4] = 5 - 7, branch to 6
    load_t1();
    base = log0.size(); abase = ackc0.size();
    pulse_run0();
    step(60);
    chk("t1_mem4", mem0[4], 16'hFFFE);
    chk("t1_pc", pc0, 6);
    chk("t1_nxfer", log0.size() - base, 6);
    exp_log = '{17'h00000, 17'h00001, 17'h00002, 17'h00003, 17'h00004, 17'h10004};
    for (int i = 0; i < 6 && base + i < log0.size(); i++) chk($sformatf("t1_xfer%0d", i), log0[base + i], exp_log[i]);
    for (int i = 1; i < 6 && abase + i < ackc0.size(); i++)
      chk($sformatf("t1_gap%0d", i), ackc0[abase + i] - ackc0[abase + i - 1], 2);
    for (int i = 0; i < 32; i++) snap[i] = mem0[i];

    // halt: R=0 taken with negative C
    do_rst();
    clr();
    poke(0, 0, 10); poke(0, 1, 11); poke(0, 2, 16'h8000); poke(0, 10, 1); poke(0, 11, 1);
    pulse_run0();
    step(60);
    chk("t2_mem11", mem0[11], 0);
    chk("t2_halted", halted0, 1);
    chk("t2_pc", pc0, 0);
    n = req_n0;
    run0 = 1'b1; step(10); run0 = 1'b0; step(5); run0 = 1'b1; step(5); run0 = 1'b0;
    chk("t2_no_req", req_n0 - n, 0);
    chk("t2_still_halted", halted0, 1);
    chk("t2_pc_hold", pc0, 0);

    // output instruction with a stalled consumer
    do_rst();
    clr();
    poke(0, 0, 20); poke(0, 1, 16'hFFFF); poke(0, 2, 0); poke(0, 20, 16'h0141);
    base = log0.size();
    pulse_run0();
    for (int i = 0; i < 100 && !b0.out_valid; i++) step(1);
    chk("t3_out_valid", b0.out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk($sformatf("t3_hold_valid%0d", k), b0.out_valid, 1);
      chk($sformatf("t3_hold_data%0d", k), b0.out_data, 8'h41);
    end
    b0.out_ready = 1'b1;
    step(1);
    b0.out_ready = 1'b0;
    chk("t3_valid_drop", b0.out_valid, 0);
    step(10);
    chk("t3_pc", pc0, 3);
    chk("t3_nxfer", log0.size() - base, 4);
    w = 0;
    for (int i = base; i < log0.size(); i++) w += int'(log0[i][16]);
    chk("t3_no_write", w, 0);

    // input instruction with late producer
    do_rst();
    clr();
    poke(0, 0, 16'hFFFF); poke(0, 1, 30); poke(0, 2, 0);
    base = log0.size();
    b0.in_data = 8'h5A;
    pulse_run0();
    for (int i = 0; i < 100 && !b0.in_ready; i++) step(1);
    chk("t4_in_ready", b0.in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk($sformatf("t4_ready_hold%0d", k), b0.in_ready, 1);
    end
    b0.in_valid = 1'b1;
    step(1);
    b0.in_valid = 1'b0;
    chk("t4_ready_drop", b0.in_ready, 0);
    step(20);
    chk("t4_mem30", mem0[30], 16'h005A);
    chk("t4_pc", pc0, 3);
    chk("t4_nxfer", log0.size() - base, 4);
    if (log0.size() > 0) chk("t4_last_xfer", log0[log0.size() - 1], 17'h1001E);

    // pc wrap on the RESET_PC=0xFFFE core, not-taken result
    poke(1, 16'hFFFE, 100); poke(1, 16'hFFFF, 101); poke(1, 0, 50); poke(1, 100, 1); poke(1, 101, 5);
    base = log1.size();
    run1 = 1'b1; step(1); run1 = 1'b0;
    step(60);
    chk("t5_nxfer", log1.size() - base, 6);
    exp_log[0] = 17'h0FFFE; exp_log[1] = 17'h0FFFF; exp_log[2] = 17'h00000;
    for (int i = 0; i < 3 && base + i < log1.size(); i++) chk($sformatf("t5_fetch%0d", i), log1[base + i], exp_log[i]);
    chk("t5_mem101", mem1[101], 4);
    chk("t5_pc", pc1, 16'h0001);

    // same program as the first run with random ack latency
    do_rst();
    mode = 1;
    load_t1();
    pulse_run0();
    step(150);
    for (int i = 0; i < 32; i++) chk($sformatf("t6_img%0d", i), mem0[i], snap[i]);
    chk("t6_pc", pc0, 6);

    // reset while the LB read is outstanding
    do_rst();
    mode = 2;
    load_t1();
    run0 = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && !(b0.mem_req && b0.mem_addr == 16'd4 && !b0.mem_we); i++) begin
      step(1);
      run0 = 1'b0;
    end
    run0 = 1'b0;
    chk("t7_lb_seen", b0.mem_req && b0.mem_addr == 16'd4 && !b0.mem_we, 1);
    rst = 1'b1;
    step(1);
    chk("t7_req_drop", b0.mem_req, 0);
    chk("t7_pc", pc0, 0);
    rst = 1'b0;
    mode = 0;
    n = req_n0;
    step(10);
    chk("t7_idle_no_req", req_n0 - n, 0);
    pulse_run0();
    step(1);
    chk("t7_restart_req", b0.mem_req, 1);
    chk("t7_restart_addr", b0.mem_addr, 0);
    step(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
